toast_hazard_unit: RTL and testbench

//   Parametrised hazard/forwarding controller for deeper Toast pipelines. Selects operand forwarding

---
 rtl/toast_hazard_unit_if.sv | 54 +++++
 rtl/toast_hazard_unit.sv | 138 +++++++++++++
 tb/tb_toast_hazard_unit.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toast_hazard_unit_if.sv
// Toast hazard unit bundle: decode-side operands, downstream
// stage info, long-op completion, redirect, and control outputs.
interface toast_hazard_unit_if #(
  parameter int AW          = 5,
  parameter int FWD_STAGES  = 2,
  parameter int MAX_PENDING = 4
);
  localparam int FSW = $clog2(FWD_STAGES + 1);
  localparam int CW  = $clog2(MAX_PENDING + 1);

  logic                     ID_valid_i;
  logic [AW-1:0]            ID_rs1_addr_i;
  logic [AW-1:0]            ID_rs2_addr_i;
  logic                     ID_rs1_used_i;
  logic                     ID_rs2_used_i;
  logic [AW-1:0]            ID_rd_addr_i;
  logic                     ID_rd_wr_en_i;
  logic                     ID_long_op_i;
  logic [FWD_STAGES*AW-1:0] FWD_rd_addr_i;
  logic [FWD_STAGES-1:0]    FWD_rd_wr_en_i;
  logic [FWD_STAGES-1:0]    FWD_is_load_i;
  logic                     long_done_i;
  logic [AW-1:0]            long_rd_addr_i;
  logic                     redirect_i;
  logic                     redirect_branch_i;
  logic [FSW-1:0]           forwardA_o;
  logic [FSW-1:0]           forwardB_o;
  logic                     stall_o;
  logic                     IF_ID_flush_o;
  logic                     EX_flush_o;
  logic [CW-1:0]            pending_cnt_o;

  modport master (
    output ID_valid_i, ID_rs1_addr_i, ID_rs2_addr_i,
    output ID_rs1_used_i, ID_rs2_used_i,
    output ID_rd_addr_i, ID_rd_wr_en_i, ID_long_op_i,
    output FWD_rd_addr_i, FWD_rd_wr_en_i, FWD_is_load_i,
    output long_done_i, long_rd_addr_i,
    output redirect_i, redirect_branch_i,
    input  forwardA_o, forwardB_o, stall_o,
    input  IF_ID_flush_o, EX_flush_o, pending_cnt_o
  );

  modport slave (
    input  ID_valid_i, ID_rs1_addr_i, ID_rs2_addr_i,
    input  ID_rs1_used_i, ID_rs2_used_i,
    input  ID_rd_addr_i, ID_rd_wr_en_i, ID_long_op_i,
    input  FWD_rd_addr_i, FWD_rd_wr_en_i, FWD_is_load_i,
    input  long_done_i, long_rd_addr_i,
    input  redirect_i, redirect_branch_i,
    output forwardA_o, forwardB_o, stall_o,
    output IF_ID_flush_o, EX_flush_o, pending_cnt_o
  );
endinterface

// File: rtl/toast_hazard_unit.sv
// Toast hazard unit: operand forwarding, load-use and long-op
// scoreboard stalls, and multi-cycle IF/ID flush sequencing.
module toast_hazard_unit #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int FWD_STAGES         = 2,
  parameter int LOAD_LATENCY       = 1,
  parameter int BRANCH_FLUSH       = 2,
  parameter int MAX_PENDING        = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  toast_hazard_unit_if.slave hz
);
  localparam int AW   = REGFILE_ADDR_WIDTH;
  localparam int NREG = 2 ** AW;
  localparam int FSW  = $clog2(FWD_STAGES + 1);
  localparam int CW   = $clog2(MAX_PENDING + 1);
  localparam int FCW  = (BRANCH_FLUSH > 1) ?
                        $clog2(BRANCH_FLUSH) : 1;

  typedef enum logic {
    IDLE,
    FLUSH
  } fstate_e;

  fstate_e         state_q;
  logic [FCW-1:0]  fcnt_q;
  logic [NREG-1:0] sb_q, sb_d;
  logic [CW-1:0]   pend_q, pend_d;

  logic [FSW:0]    pick_a, pick_b;
  logic            flush;
  logic            raw, waw, full;
  logic            stall;
  logic            issue;
  logic            done;

  // Nearest matching stage wins outright; a too-young load
  // there yields a load-use flag (top bit) instead of a select.
  function automatic logic [FSW:0] fwd_pick(
    input logic [AW-1:0]            rs,
    input logic                     used,
    input logic [FWD_STAGES*AW-1:0] rd,
    input logic [FWD_STAGES-1:0]    we,
    input logic [FWD_STAGES-1:0]    ld
  );
    logic         hit;
    logic [FSW:0] r;
    hit = 1'b0;
    r   = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (!hit && used && rs != '0 && we[k] &&
          rd[k*AW +: AW] == rs) begin
        hit = 1'b1;
        if (ld[k] && k < LOAD_LATENCY)
          r[FSW] = 1'b1;
        else
          r[FSW-1:0] = FSW'(k + 1);
      end
    end
    return r;
  endfunction

  // Hazard detection and issue qualification.
  always_comb begin
    pick_a = fwd_pick(hz.ID_rs1_addr_i, hz.ID_rs1_used_i,
                      hz.FWD_rd_addr_i, hz.FWD_rd_wr_en_i,
                      hz.FWD_is_load_i);
    pick_b = fwd_pick(hz.ID_rs2_addr_i, hz.ID_rs2_used_i,
                      hz.FWD_rd_addr_i, hz.FWD_rd_wr_en_i,
                      hz.FWD_is_load_i);
    flush  = hz.redirect_i | (state_q == FLUSH);
    raw    = (hz.ID_rs1_used_i & sb_q[hz.ID_rs1_addr_i]) |
             (hz.ID_rs2_used_i & sb_q[hz.ID_rs2_addr_i]);
    waw    = hz.ID_rd_wr_en_i & sb_q[hz.ID_rd_addr_i];
    full   = hz.ID_long_op_i &
             (pend_q == CW'(MAX_PENDING));
    stall  = hz.ID_valid_i & ~flush &
             (pick_a[FSW] | pick_b[FSW] | raw | waw | full);
    issue  = hz.ID_valid_i & hz.ID_long_op_i &
             hz.ID_rd_wr_en_i & ~stall & ~flush &
             (hz.ID_rd_addr_i != '0);
    done   = hz.long_done_i & sb_q[hz.long_rd_addr_i];
  end

  // Scoreboard next state: retire, then set on issue.
  always_comb begin
    sb_d   = sb_q;
    pend_d = pend_q;
    if (done)
      sb_d[hz.long_rd_addr_i] = 1'b0;
    if (issue)
      sb_d[hz.ID_rd_addr_i] = 1'b1;
    if (issue && !done)
      pend_d = pend_q + 1'b1;
    else if (done && !issue)
      pend_d = pend_q - 1'b1;
  end

  // Scoreboard and pending count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q   <= '0;
      pend_q <= '0;
    end else begin
      sb_q   <= sb_d;
      pend_q <= pend_d;
    end
  end

  // Flush sequencer; a redirect mid-flush restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else if (hz.redirect_i) begin
      if (BRANCH_FLUSH > 1) begin
        state_q <= FLUSH;
        fcnt_q  <= FCW'(BRANCH_FLUSH - 1);
      end
    end else if (state_q == FLUSH) begin
      if (fcnt_q == FCW'(1)) begin
        state_q <= IDLE;
        fcnt_q  <= '0;
      end else begin
        fcnt_q  <= fcnt_q - 1'b1;
      end
    end
  end

  assign hz.forwardA_o    = rst_i ? '0 : pick_a[FSW-1:0];
  assign hz.forwardB_o    = rst_i ? '0 : pick_b[FSW-1:0];
  assign hz.stall_o       = ~rst_i & stall;
  assign hz.IF_ID_flush_o = ~rst_i & flush;
  assign hz.EX_flush_o    = ~rst_i & hz.redirect_i &
                            hz.redirect_branch_i;
  assign hz.pending_cnt_o = rst_i ? '0 : pend_q;
endmodule

// File: tb/tb_toast_hazard_unit.sv
// Directed bench for toast_hazard_unit: forwarding, load-use,
// scoreboard, flush sequencing and reset, checked by assertions.
module tb_toast_hazard_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  toast_hazard_unit_if #(
    .AW(5), .FWD_STAGES(2), .MAX_PENDING(4)
  ) bus ();

  toast_hazard_unit #(
    .REGFILE_ADDR_WIDTH(5),
    .FWD_STAGES(2),
    .LOAD_LATENCY(1),
    .BRANCH_FLUSH(2),
    .MAX_PENDING(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .hz(bus.slave)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (fail #%0d)",
             tag, obs, exp, fails);
    end
  endtask

  task automatic clr();
    bus.ID_valid_i        = 1'b0;
    bus.ID_rs1_addr_i     = '0;
    bus.ID_rs2_addr_i     = '0;
    bus.ID_rs1_used_i     = 1'b0;
    bus.ID_rs2_used_i     = 1'b0;
    bus.ID_rd_addr_i      = '0;
    bus.ID_rd_wr_en_i     = 1'b0;
    bus.ID_long_op_i      = 1'b0;
    bus.FWD_rd_addr_i     = '0;
    bus.FWD_rd_wr_en_i    = '0;
    bus.FWD_is_load_i     = '0;
    bus.long_done_i       = 1'b0;
    bus.long_rd_addr_i    = '0;
    bus.redirect_i        = 1'b0;
    bus.redirect_branch_i = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic long_issue(input logic [4:0] rd);
    clr();
    bus.ID_valid_i    = 1'b1;
    bus.ID_long_op_i  = 1'b1;
    bus.ID_rd_wr_en_i = 1'b1;
    bus.ID_rd_addr_i  = rd;
  endtask

  initial begin
    // reset: outputs forced low despite active inputs
    clr();
    bus.redirect_i        = 1'b1;
    bus.redirect_branch_i = 1'b1;
    bus.ID_valid_i        = 1'b1;
    bus.ID_rs1_addr_i     = 5'd5;
    bus.ID_rs1_used_i     = 1'b1;
    bus.FWD_rd_addr_i     = {5'd0, 5'd5};
    bus.FWD_rd_wr_en_i    = 2'b01;
    bus.ID_long_op_i      = 1'b1;
    bus.ID_rd_wr_en_i     = 1'b1;
    bus.ID_rd_addr_i      = 5'd3;
    #2;
    chk("rst_fwdA", 8'(bus.forwardA_o), 8'd0);
    chk("rst_ifid", 8'(bus.IF_ID_flush_o), 8'd0);
    chk("rst_exfl", 8'(bus.EX_flush_o), 8'd0);
    chk("rst_stall", 8'(bus.stall_o), 8'd0);
    chk("rst_pend", 8'(bus.pending_cnt_o), 8'd0);
    tick();
    tick();
    rst = 1'b0;
    clr();
    #1;
    chk("post_rst_pend", 8'(bus.pending_cnt_o), 8'd0);
    chk("post_rst_ifid", 8'(bus.IF_ID_flush_o), 8'd0);

    // forwarding: nearest stage wins
    bus.ID_valid_i     = 1'b1;
    bus.ID_rs1_addr_i  = 5'd5;
    bus.ID_rs1_used_i  = 1'b1;
    bus.ID_rs2_addr_i  = 5'd5;
    bus.FWD_rd_addr_i  = {5'd5, 5'd5};
    bus.FWD_rd_wr_en_i = 2'b11;
    #1;
    chk("fwd_near_A", 8'(bus.forwardA_o), 8'd1);
    chk("fwd_unused_B", 8'(bus.forwardB_o), 8'd0);
    chk("fwd_near_stall", 8'(bus.stall_o), 8'd0);
    bus.FWD_rd_wr_en_i = 2'b10;
    #1;
    chk("fwd_st1_A", 8'(bus.forwardA_o), 8'd2);
    bus.ID_rs1_addr_i  = 5'd0;
    bus.FWD_rd_addr_i  = {5'd0, 5'd0};
    bus.FWD_rd_wr_en_i = 2'b11;
    #1;
    chk("fwd_x0_A", 8'(bus.forwardA_o), 8'd0);

    // load-use: young load blocks, no fallback to stage1
    clr();
    bus.ID_valid_i     = 1'b1;
    bus.ID_rs2_addr_i  = 5'd7;
    bus.ID_rs2_used_i  = 1'b1;
    bus.FWD_rd_addr_i  = {5'd7, 5'd7};
    bus.FWD_rd_wr_en_i = 2'b11;
    bus.FWD_is_load_i  = 2'b01;
    #1;
    chk("lu_fwdB", 8'(bus.forwardB_o), 8'd0);
    chk("lu_stall", 8'(bus.stall_o), 8'd1);
    bus.ID_rs2_used_i = 1'b0;
    #1;
    chk("lu_unused_stall", 8'(bus.stall_o), 8'd0);
    bus.ID_rs2_used_i = 1'b1;
    tick();
    bus.FWD_rd_addr_i  = {5'd7, 5'd0};
    bus.FWD_rd_wr_en_i = 2'b10;
    bus.FWD_is_load_i  = 2'b10;
    #1;
    chk("lu_next_fwdB", 8'(bus.forwardB_o), 8'd2);
    chk("lu_next_stall", 8'(bus.stall_o), 8'd0);

    // long op to x9: RAW/WAW stall until done, no bypass
    long_issue(5'd9);
    #1;
    chk("long9_issue_stall", 8'(bus.stall_o), 8'd0);
    tick();
    clr();
    bus.ID_valid_i    = 1'b1;
    bus.ID_rs1_addr_i = 5'd9;
    bus.ID_rs1_used_i = 1'b1;
    #1;
    chk("long9_pend", 8'(bus.pending_cnt_o), 8'd1);
    chk("long9_raw", 8'(bus.stall_o), 8'd1);
    bus.ID_rs1_used_i = 1'b0;
    bus.ID_rd_addr_i  = 5'd9;
    bus.ID_rd_wr_en_i = 1'b1;
    #1;
    chk("long9_waw", 8'(bus.stall_o), 8'd1);
    bus.ID_rs1_used_i = 1'b1;
    bus.ID_rd_wr_en_i = 1'b0;
    tick();
    bus.long_done_i    = 1'b1;
    bus.long_rd_addr_i = 5'd9;
    #1;
    chk("long9_done_nobyp", 8'(bus.stall_o), 8'd1);
    tick();
    bus.long_done_i = 1'b0;
    #1;
    chk("long9_after", 8'(bus.stall_o), 8'd0);
    chk("long9_pend0", 8'(bus.pending_cnt_o), 8'd0);
    clr();
    bus.long_done_i    = 1'b1;
    bus.long_rd_addr_i = 5'd12;
    tick();
    bus.long_done_i = 1'b0;
    #1;
    chk("spurious_done", 8'(bus.pending_cnt_o), 8'd0);

    // fill to MAX_PENDING, fifth waits for a retire
    for (int r = 1; r <= 4; r++) begin
      long_issue(5'(r));
      tick();
    end
    clr();
    #1;
    chk("full_pend", 8'(bus.pending_cnt_o), 8'd4);
    long_issue(5'd6);
    #1;
    chk("full_stall", 8'(bus.stall_o), 8'd1);
    bus.long_done_i    = 1'b1;
    bus.long_rd_addr_i = 5'd1;
    #1;
    chk("full_done_stall", 8'(bus.stall_o), 8'd1);
    tick();
    bus.long_done_i = 1'b0;
    #1;
    chk("retire_pend", 8'(bus.pending_cnt_o), 8'd3);
    chk("fifth_stall", 8'(bus.stall_o), 8'd0);
    tick();
    clr();
    bus.ID_valid_i    = 1'b1;
    bus.ID_rs1_addr_i = 5'd1;
    bus.ID_rs1_used_i = 1'b1;
    #1;
    chk("fifth_pend", 8'(bus.pending_cnt_o), 8'd4);
    chk("x1_free", 8'(bus.stall_o), 8'd0);
    bus.ID_rs1_addr_i = 5'd2;
    #1;
    chk("x2_busy", 8'(bus.stall_o), 8'd1);
    clr();
    bus.long_done_i    = 1'b1;
    bus.long_rd_addr_i = 5'd2;
    tick();
    clr();
    #1;
    chk("retire2_pend", 8'(bus.pending_cnt_o), 8'd3);

    // branch redirect: flush beats stall, blocks issue
    bus.ID_valid_i        = 1'b1;
    bus.ID_rs1_addr_i     = 5'd3;
    bus.ID_rs1_used_i     = 1'b1;
    bus.ID_long_op_i      = 1'b1;
    bus.ID_rd_wr_en_i     = 1'b1;
    bus.ID_rd_addr_i      = 5'd10;
    bus.redirect_i        = 1'b1;
    bus.redirect_branch_i = 1'b1;
    #1;
    chk("t0_exfl", 8'(bus.EX_flush_o), 8'd1);
    chk("t0_ifid", 8'(bus.IF_ID_flush_o), 8'd1);
    chk("t0_stall", 8'(bus.stall_o), 8'd0);
    tick();
    bus.redirect_i        = 1'b0;
    bus.redirect_branch_i = 1'b0;
    #1;
    chk("t1_exfl", 8'(bus.EX_flush_o), 8'd0);
    chk("t1_ifid", 8'(bus.IF_ID_flush_o), 8'd1);
    chk("t1_stall", 8'(bus.stall_o), 8'd0);
    chk("t1_pend", 8'(bus.pending_cnt_o), 8'd3);
    tick();
    chk("t2_ifid", 8'(bus.IF_ID_flush_o), 8'd0);
    chk("t2_stall", 8'(bus.stall_o), 8'd1);
    chk("t2_pend", 8'(bus.pending_cnt_o), 8'd3);
    bus.ID_valid_i = 1'b0;

    // jump redirect restarted mid-flush
    bus.redirect_i = 1'b1;
    #1;
    chk("j0_exfl", 8'(bus.EX_flush_o), 8'd0);
    chk("j0_ifid", 8'(bus.IF_ID_flush_o), 8'd1);
    tick();
    chk("j1_ifid", 8'(bus.IF_ID_flush_o), 8'd1);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    chk("j2_ifid", 8'(bus.IF_ID_flush_o), 8'd1);
    tick();
    chk("j3_ifid", 8'(bus.IF_ID_flush_o), 8'd0);

    // reset mid-flush with three pending
    bus.redirect_i = 1'b1;
    tick();
    bus.redirect_i = 1'b0;
    rst = 1'b1;
    bus.ID_valid_i    = 1'b1;
    bus.ID_rs1_addr_i = 5'd3;
    bus.ID_rs1_used_i = 1'b1;
    #1;
    chk("mid_rst_ifid", 8'(bus.IF_ID_flush_o), 8'd0);
    chk("mid_rst_pend", 8'(bus.pending_cnt_o), 8'd0);
    chk("mid_rst_stall", 8'(bus.stall_o), 8'd0);
    tick();
    rst = 1'b0;
    bus.ID_rs2_addr_i = 5'd6;
    bus.ID_rs2_used_i = 1'b1;
    bus.ID_rd_addr_i  = 5'd4;
    bus.ID_rd_wr_en_i = 1'b1;
    #1;
    chk("after_rst_pend", 8'(bus.pending_cnt_o), 8'd0);
    chk("after_rst_ifid", 8'(bus.IF_ID_flush_o), 8'd0);
    chk("after_rst_stall", 8'(bus.stall_o), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
